// File: rtl/controller_poller_pkg.sv
// -----------------------------------------------------------------------------
// controller_poller_pkg
//
// Shared definitions for the serial game-pad poller:
//   - poll_state_t     : poller FSM states (IDLE, LATCH, SHIFT, DONE)
//   - *_DEF            : default parameter values for controller_poller_m
//   - *_MIN / *_MAX    : legal ranges for NUM_CONTROLLERS and NUM_BUTTONS
//   - CNT_W            : width of the shift-cycle counter, sized for the
//                        largest legal NUM_BUTTONS
//   - cfg_legal()      : helper that reports whether a configuration is legal
//
// Optional feature macro used by the poller: CONTROLLER_POLLER_EDGE_EN
// (enables the sticky pressed-edge flags).
// -----------------------------------------------------------------------------
package controller_poller_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } poll_state_t;

  localparam int NUM_CONTROLLERS_DEF = 2;
  localparam int NUM_BUTTONS_DEF     = 8;

  localparam int NUM_CONTROLLERS_MIN = 1;
  localparam int NUM_CONTROLLERS_MAX = 4;
  localparam int NUM_BUTTONS_MIN     = 8;
  localparam int NUM_BUTTONS_MAX     = 16;

  // Counter only needs to reach NUM_BUTTONS-1 (at most 15).
  localparam int CNT_W = $clog2(NUM_BUTTONS_MAX);

  function automatic bit cfg_legal(input int num_controllers,
                                   input int num_buttons);
    return (num_controllers >= NUM_CONTROLLERS_MIN) &&
           (num_controllers <= NUM_CONTROLLERS_MAX) &&
           (num_buttons     >= NUM_BUTTONS_MIN)     &&
           (num_buttons     <= NUM_BUTTONS_MAX);
  endfunction

endpackage

// File: rtl/controller_poller_m_shift.sv
// -----------------------------------------------------------------------------
// controller_shift_m
//
// Working shift register for one serial pad. Each enabled cycle the inverted
// (active-low to active-high) pad bit is shifted in at the LSB end, so the
// first bit sampled ends up in the MSB after NUM_BUTTONS shifts.
//
// Ports:
//   clk_1      in   system clock
//   rst        in   asynchronous active-high reset
//   clear      in   synchronous clear of the working register (start of poll)
//   shift_en   in   sample data_in_B and shift this cycle
//   data_in_B  in   serial pad data, active-low
//   work       out  working register contents, active-high
// -----------------------------------------------------------------------------
module controller_shift_m
  import controller_poller_pkg::*;
#(
  parameter int NUM_BUTTONS = NUM_BUTTONS_DEF
) (
  input  logic                   clk_1,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   shift_en,
  input  logic                   data_in_B,
  output logic [NUM_BUTTONS-1:0] work
);

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      work <= '0;
    end else if (clear) begin
      work <= '0;
    end else if (shift_en) begin
      work <= {work[NUM_BUTTONS-2:0], ~data_in_B};
    end
  end

endmodule

// File: rtl/controller_poller_m.sv
// -----------------------------------------------------------------------------
// controller_poller_m
//
// Polls NUM_CONTROLLERS serial game pads in parallel. A poll_start pulse
// latches all pads, shifts NUM_BUTTONS bits out of each, then publishes the
// complete set of button states at once.
//
// Timeline after poll_start is accepted in IDLE:
//   LATCH (1 cycle)           controller_latch high
//   SHIFT (NUM_BUTTONS cyc.)  one pad bit sampled per cycle, MSB first;
//                             controller_clk_enable high in all but the last
//   DONE  (1 cycle)           poll_done high; buttons_out (and pressed_out)
//                             take their new values at the end of this cycle
// poll_start is ignored unless the FSM is IDLE.
//
// Ports:
//   clk_1                  in   system clock
//   rst                    in   asynchronous active-high reset
//   poll_start             in   single-cycle poll request
//   pressed_clear          in   single-cycle clear of pressed_out
//   controller_latch       out  pad latch strobe (all pads)
//   controller_clk_enable  out  pad shift-advance enable (all pads)
//   controller_data_in_B   in   serial pad data, active-low, bit k = pad k
//   buttons_out            out  button state per pad, active-high,
//                               pad k in [k*NUM_BUTTONS +: NUM_BUTTONS]
//   pressed_out            out  sticky 0->1 edge flags, same layout
//   busy                   out  high from LATCH through DONE
//   poll_done              out  single-cycle pulse in DONE
//
// Configuration macro: CONTROLLER_POLLER_EDGE_EN
//   defined   : pressed_out tracks rising button edges, pressed_clear clears
//   undefined : pressed_out is constant 0, pressed_clear is ignored
// -----------------------------------------------------------------------------
module controller_poller_m
  import controller_poller_pkg::*;
#(
  parameter int NUM_CONTROLLERS = NUM_CONTROLLERS_DEF,
  parameter int NUM_BUTTONS     = NUM_BUTTONS_DEF
) (
  input  logic                                   clk_1,
  input  logic                                   rst,
  input  logic                                   poll_start,
  input  logic                                   pressed_clear,
  output logic                                   controller_latch,
  output logic                                   controller_clk_enable,
  input  logic [NUM_CONTROLLERS-1:0]             controller_data_in_B,
  output logic [NUM_CONTROLLERS*NUM_BUTTONS-1:0] buttons_out,
  output logic [NUM_CONTROLLERS*NUM_BUTTONS-1:0] pressed_out,
  output logic                                   busy,
  output logic                                   poll_done
);

  localparam int TOT_W = NUM_CONTROLLERS * NUM_BUTTONS;

  // Index of the last SHIFT cycle, and of the last one that advances the pad.
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BUTTONS - 1);
  localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(NUM_BUTTONS - 2);

  poll_state_t      state;
  logic [CNT_W-1:0] shift_cnt;
  logic [TOT_W-1:0] work_all;
  logic             work_clear;
  logic             work_shift;

  // Working registers are zeroed while the pads latch, so every poll starts
  // from a clean slate regardless of what a previous (or aborted) poll left.
  assign work_clear = (state == LATCH);
  assign work_shift = (state == SHIFT);

  for (genvar k = 0; k < NUM_CONTROLLERS; k++) begin : g_pad
    controller_shift_m #(
      .NUM_BUTTONS (NUM_BUTTONS)
    ) u_shift (
      .clk_1     (clk_1),
      .rst       (rst),
      .clear     (work_clear),
      .shift_en  (work_shift),
      .data_in_B (controller_data_in_B[k]),
      .work      (work_all[k*NUM_BUTTONS +: NUM_BUTTONS])
    );
  end

  // Poll sequencer: all strobes are registered alongside the state so they
  // line up exactly with the state they belong to.
  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      state                 <= IDLE;
      shift_cnt             <= '0;
      controller_latch      <= 1'b0;
      controller_clk_enable <= 1'b0;
      busy                  <= 1'b0;
      poll_done             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (poll_start) begin
            state            <= LATCH;
            controller_latch <= 1'b1;
            busy             <= 1'b1;
          end
        end
        LATCH: begin
          state                 <= SHIFT;
          shift_cnt             <= '0;
          controller_latch      <= 1'b0;
          controller_clk_enable <= 1'b1;
        end
        SHIFT: begin
          if (shift_cnt == LAST_BIT) begin
            state                 <= DONE;
            controller_clk_enable <= 1'b0;
            poll_done             <= 1'b1;
          end else begin
            shift_cnt             <= shift_cnt + CNT_W'(1);
            // Next cycle advances the pad only if it is not the last bit.
            controller_clk_enable <= (shift_cnt < LAST_CLK);
          end
        end
        DONE: begin
          state     <= IDLE;
          poll_done <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state                 <= IDLE;
          controller_latch      <= 1'b0;
          controller_clk_enable <= 1'b0;
          busy                  <= 1'b0;
          poll_done             <= 1'b0;
        end
      endcase
    end
  end

  // All pads publish together from the fully shifted working registers.
  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      buttons_out <= '0;
    end else if (state == DONE) begin
      buttons_out <= work_all;
    end
  end

`ifdef CONTROLLER_POLLER_EDGE_EN
  // A clear coincident with DONE wipes the old flags first, so edges found
  // in this poll still survive.
  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      pressed_out <= '0;
    end else if (state == DONE) begin
      pressed_out <= (pressed_clear ? '0 : pressed_out) |
                     (work_all & ~buttons_out);
    end else if (pressed_clear) begin
      pressed_out <= '0;
    end
  end
`else
  logic unused_pressed_clear;
  assign unused_pressed_clear = pressed_clear;
  assign pressed_out          = '0;
`endif

endmodule

// File: doc/controller_poller_m.md
CONTROLLER_POLLER_M -- requirements
Module: controller_poller_m

Interface
REQ-001 SHALL have parameter NUM_CONTROLLERS, default 2, number of serial pads polled in parallel (legal 1..4).
REQ-002 SHALL have parameter NUM_BUTTONS, default 8, bits shifted per pad (legal 8..16).
REQ-003 SHALL have port clk_1  input  1  system clock; one clock only, all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port poll_start  input  1  single-cycle request to begin a poll (typically vblank).
REQ-006 SHALL have port pressed_clear  input  1  single-cycle clear of the pressed flags.
REQ-007 SHALL have port controller_latch  output  1  pad latch strobe, shared by all pads.
REQ-008 SHALL have port controller_clk_enable  output  1  pad shift-advance enable, shared by all pads.
REQ-009 SHALL have port controller_data_in_B  input  NUM_CONTROLLERS  serial pad data, active-low, bit k = pad k.
REQ-010 SHALL have port buttons_out  output  NUM_CONTROLLERS*NUM_BUTTONS  debounced-by-frame button state, active-high, pad k in slice [k*NUM_BUTTONS +: NUM_BUTTONS].
REQ-011 SHALL have port pressed_out  output  NUM_CONTROLLERS*NUM_BUTTONS  sticky 0->1 button-edge flags, same layout.
REQ-012 SHALL have port busy  output  1  high from LATCH through DONE inclusive.
REQ-013 SHALL have port poll_done  output  1  single-cycle pulse when buttons_out updates.

Function
REQ-014 SHALL implement FSM states IDLE, LATCH, SHIFT, DONE.
REQ-015 SHALL go IDLE->LATCH on poll_start; LATCH->SHIFT after exactly 1 cycle; SHIFT->DONE after exactly NUM_BUTTONS cycles; DONE->IDLE after 1 cycle.
REQ-016 SHALL assert controller_latch only in LATCH.
REQ-017 SHALL assert controller_clk_enable in SHIFT cycles 0..NUM_BUTTONS-2 only (NUM_BUTTONS-1 pulses).
REQ-018 SHALL sample ~controller_data_in_B[k] in SHIFT cycle i into working bit NUM_BUTTONS-1-i of pad k (first bit = MSB).
REQ-019 SHALL update buttons_out for all pads atomically in DONE (no partial values visible); latency poll_start to buttons_out change = NUM_BUTTONS+2 cycles.
REQ-020 SHALL pulse poll_done in the DONE cycle.
REQ-021 SHALL ignore poll_start while busy (no restart, no queueing).
REQ-022 SHALL, in DONE, set pressed_out |= new & ~old buttons_out.
REQ-023 SHALL clear pressed_out on pressed_clear; if coincident with DONE, clear first then OR new edges (new edges survive).
REQ-024 SHALL hold buttons_out and pressed_out stable between polls.

Reset
REQ-025 SHALL, on rst assertion at any time (including mid-SHIFT), go to IDLE immediately with buttons_out=0, pressed_out=0, busy=0, poll_done=0, controller_latch=0, controller_clk_enable=0, working registers=0.
REQ-026 SHALL discard any partial poll on reset; first poll after release behaves as from power-up.

Configuration
REQ-027 SHALL compile pressed-edge logic only when CONTROLLER_POLLER_EDGE_EN is defined; without it pressed_out is constant 0, pressed_clear is ignored, and no edge registers exist; all other behaviour identical.

Structure
REQ-028 SHALL place state enum, parameter defaults and legal-range constants in package controller_poller_pkg.
REQ-029 SHALL instantiate one sub-module controller_shift_m per pad (working shift register plus sampling), generated NUM_CONTROLLERS times.

Verification
REQ-030 Defaults; pad0 holds 8'b10001001, pad1 8'b00100110; poll_start -> after 10 cycles buttons_out=16'b00100110_10001001, poll_done one cycle, latch 1 cycle, 7 clk_enable pulses.
REQ-031 EDGE_EN; poll with 8'h00 then 8'h81 on pad0 -> pressed_out[7:0]=8'h81; pressed_clear -> 8'h00; repeat 8'h81 poll -> stays 8'h00.
REQ-032 poll_start reasserted in SHIFT cycle 3 -> ignored, poll_done once, total busy 10 cycles.
REQ-033 rst asserted in SHIFT cycle 4 -> all outputs 0 same cycle; next poll returns correct values.
REQ-034 NUM_CONTROLLERS=4, NUM_BUTTONS=12, pads 12'hA5C,12'h001,12'hFFF,12'h800 -> buttons_out=48'h800FFF001A5C after 14 cycles.
REQ-035 pressed_clear coincident with DONE where pad0 goes 8'h00->8'h04 -> pressed_out[7:0]=8'h04.
